// File: rtl/cpu_datapath_pkg.sv
// Shared constants for the single-bus CPU datapath: data width and bus encoder codes.
package cpu_datapath_pkg;

   localparam int DATA_WIDTH = 32;

   localparam logic [4:0] ENC_HI     = 5'd16;
   localparam logic [4:0] ENC_LO     = 5'd17;
   localparam logic [4:0] ENC_ZHI    = 5'd18;
   localparam logic [4:0] ENC_ZLO    = 5'd19;
   localparam logic [4:0] ENC_PC     = 5'd20;
   localparam logic [4:0] ENC_MDR    = 5'd21;
   localparam logic [4:0] ENC_INPORT = 5'd22;
   localparam logic [4:0] ENC_Y      = 5'd24;
   localparam logic [4:0] ENC_NONE   = 5'd31;

endpackage

// File: rtl/cpu_reg32.sv
// Datapath register with synchronous clear and load enable.
module cpu_reg32
   import cpu_datapath_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) q_d = d;
   end

   always_ff @(posedge Clock) begin
      if (Clear) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, special registers, bus encoder/mux and a minimal ALU.
module cpu_datapath
   import cpu_datapath_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
   input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic             HIin,  LOin,  PCin,  MDRin, INPORTin, Zin, Yin, MARin, IRin,
   input  logic             AND,
   input  logic             R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
   input  logic             R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic             HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Zout, Yout,
   input  logic             Read,
   input  logic             IncPC,
   input  logic [WIDTH-1:0] Mdatain,
   output logic [WIDTH-1:0] busMuxOut,
   output logic [4:0]       encoderOut,
   output logic [WIDTH-1:0] BusMuxInR0,  BusMuxInR1,  BusMuxInR2,  BusMuxInR3,
   output logic [WIDTH-1:0] BusMuxInR4,  BusMuxInR5,  BusMuxInR6,  BusMuxInR7,
   output logic [WIDTH-1:0] BusMuxInR8,  BusMuxInR9,  BusMuxInR10, BusMuxInR11,
   output logic [WIDTH-1:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
   output logic [WIDTH-1:0] BusMuxInHI,  BusMuxInLO,  BusMuxInZhi, BusMuxInZlo,
   output logic [WIDTH-1:0] BusMuxInPC,  BusMuxInMDR, BusMuxInInport, BusMuxInY
);

   logic [15:0]      r_in;
   logic [WIDTH-1:0] r_val [16];
   logic [31:0]      sel_vec;
   logic [4:0]       enc_code;
   logic [WIDTH-1:0] bus;
   logic [WIDTH-1:0] mdr_d;
   logic [2*WIDTH-1:0] z_alu;
   logic [WIDTH-1:0] mar_val;
   logic [WIDTH-1:0] ir_val;

   assign r_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

   for (genvar i = 0; i < 16; i++) begin : g_gpr
      cpu_reg32 #(.WIDTH(WIDTH)) u_r (
         .Clock(Clock), .Clear(Clear), .load(r_in[i]), .d(bus), .q(r_val[i])
      );
   end

   cpu_reg32 #(.WIDTH(WIDTH)) u_hi  (.Clock(Clock), .Clear(Clear), .load(HIin),     .d(bus),   .q(BusMuxInHI));
   cpu_reg32 #(.WIDTH(WIDTH)) u_lo  (.Clock(Clock), .Clear(Clear), .load(LOin),     .d(bus),   .q(BusMuxInLO));
   cpu_reg32 #(.WIDTH(WIDTH)) u_pc  (.Clock(Clock), .Clear(Clear), .load(PCin),     .d(bus),   .q(BusMuxInPC));
   cpu_reg32 #(.WIDTH(WIDTH)) u_mdr (.Clock(Clock), .Clear(Clear), .load(MDRin),    .d(mdr_d), .q(BusMuxInMDR));
   cpu_reg32 #(.WIDTH(WIDTH)) u_inp (.Clock(Clock), .Clear(Clear), .load(INPORTin), .d(bus),   .q(BusMuxInInport));
   cpu_reg32 #(.WIDTH(WIDTH)) u_y   (.Clock(Clock), .Clear(Clear), .load(Yin),      .d(bus),   .q(BusMuxInY));
   cpu_reg32 #(.WIDTH(WIDTH)) u_mar (.Clock(Clock), .Clear(Clear), .load(MARin),    .d(bus),   .q(mar_val));
   cpu_reg32 #(.WIDTH(WIDTH)) u_ir  (.Clock(Clock), .Clear(Clear), .load(IRin),     .d(bus),   .q(ir_val));
   cpu_reg32 #(.WIDTH(WIDTH)) u_zhi (.Clock(Clock), .Clear(Clear), .load(Zin),
                                     .d(z_alu[2*WIDTH-1:WIDTH]), .q(BusMuxInZhi));
   cpu_reg32 #(.WIDTH(WIDTH)) u_zlo (.Clock(Clock), .Clear(Clear), .load(Zin),
                                     .d(z_alu[WIDTH-1:0]),       .q(BusMuxInZlo));

   // Bit position in sel_vec equals the encoder code; Zout aliases ZLO.
   assign sel_vec = {7'b0, Yout, 1'b0, INPORTout, MDRout, PCout, (ZLOout | Zout), ZHIout, LOout, HIout,
                     R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

   // Scan downward so the lowest active code is the last one assigned.
   always_comb begin
      enc_code = ENC_NONE;
      for (int i = 31; i >= 0; i--) begin
         if (sel_vec[i]) enc_code = 5'(i);
      end
   end

   always_comb begin
      bus = '0;
      if (enc_code < 5'd16) begin
         bus = r_val[enc_code[3:0]];
      end else begin
         case (enc_code)
            ENC_HI:     bus = BusMuxInHI;
            ENC_LO:     bus = BusMuxInLO;
            ENC_ZHI:    bus = BusMuxInZhi;
            ENC_ZLO:    bus = BusMuxInZlo;
            ENC_PC:     bus = BusMuxInPC;
            ENC_MDR:    bus = BusMuxInMDR;
            ENC_INPORT: bus = BusMuxInInport;
            ENC_Y:      bus = BusMuxInY;
            default:    bus = '0;
         endcase
      end
   end

   always_comb begin
      mdr_d = Read ? Mdatain : bus;
   end

   always_comb begin
      z_alu = '0;
      if (IncPC)    z_alu[WIDTH-1:0] = bus + WIDTH'(1);
      else if (AND) z_alu[WIDTH-1:0] = BusMuxInY & bus;
      else          z_alu[WIDTH-1:0] = BusMuxInY + bus;
   end

   assign busMuxOut  = bus;
   assign encoderOut = enc_code;

   assign BusMuxInR0  = r_val[0];  assign BusMuxInR1  = r_val[1];
   assign BusMuxInR2  = r_val[2];  assign BusMuxInR3  = r_val[3];
   assign BusMuxInR4  = r_val[4];  assign BusMuxInR5  = r_val[5];
   assign BusMuxInR6  = r_val[6];  assign BusMuxInR7  = r_val[7];
   assign BusMuxInR8  = r_val[8];  assign BusMuxInR9  = r_val[9];
   assign BusMuxInR10 = r_val[10]; assign BusMuxInR11 = r_val[11];
   assign BusMuxInR12 = r_val[12]; assign BusMuxInR13 = r_val[13];
   assign BusMuxInR14 = r_val[14]; assign BusMuxInR15 = r_val[15];

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed plus randomized register-transfer checks of cpu_datapath against a behavioural model.
module tb_cpu_datapath;

   localparam int I_HI = 16, I_LO = 17, I_PC = 18, I_MDR = 19, I_INP = 20,
                  I_Z = 21, I_Y = 22, I_MAR = 23, I_IR = 24;
   localparam int O_HI = 16, O_LO = 17, O_ZHI = 18, O_ZLO = 19, O_PC = 20,
                  O_MDR = 21, O_INP = 22, O_Z = 23, O_Y = 24;

   logic        Clock = 1'b0;
   logic        Clear;
   logic [24:0] in_s;
   logic [24:0] out_s;
   logic        AND_s, Read, IncPC;
   logic [31:0] Mdatain;
   logic [31:0] busMuxOut;
   logic [4:0]  encoderOut;
   logic [31:0] tap_r [16];
   logic [31:0] tap_hi, tap_lo, tap_zhi, tap_zlo, tap_pc, tap_mdr, tap_inp, tap_y;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mr [16];
   logic [31:0] mhi, mlo, mzhi, mzlo, mpc, mmdr, minp, my, mmar, mir;

   always #5 Clock = ~Clock;

   cpu_datapath dut (
      .Clock(Clock), .Clear(Clear),
      .R0in(in_s[0]),   .R1in(in_s[1]),   .R2in(in_s[2]),   .R3in(in_s[3]),
      .R4in(in_s[4]),   .R5in(in_s[5]),   .R6in(in_s[6]),   .R7in(in_s[7]),
      .R8in(in_s[8]),   .R9in(in_s[9]),   .R10in(in_s[10]), .R11in(in_s[11]),
      .R12in(in_s[12]), .R13in(in_s[13]), .R14in(in_s[14]), .R15in(in_s[15]),
      .HIin(in_s[I_HI]), .LOin(in_s[I_LO]), .PCin(in_s[I_PC]), .MDRin(in_s[I_MDR]),
      .INPORTin(in_s[I_INP]), .Zin(in_s[I_Z]), .Yin(in_s[I_Y]), .MARin(in_s[I_MAR]),
      .IRin(in_s[I_IR]),
      .AND(AND_s),
      .R0out(out_s[0]),   .R1out(out_s[1]),   .R2out(out_s[2]),   .R3out(out_s[3]),
      .R4out(out_s[4]),   .R5out(out_s[5]),   .R6out(out_s[6]),   .R7out(out_s[7]),
      .R8out(out_s[8]),   .R9out(out_s[9]),   .R10out(out_s[10]), .R11out(out_s[11]),
      .R12out(out_s[12]), .R13out(out_s[13]), .R14out(out_s[14]), .R15out(out_s[15]),
      .HIout(out_s[O_HI]), .LOout(out_s[O_LO]), .ZHIout(out_s[O_ZHI]), .ZLOout(out_s[O_ZLO]),
      .PCout(out_s[O_PC]), .MDRout(out_s[O_MDR]), .INPORTout(out_s[O_INP]),
      .Zout(out_s[O_Z]), .Yout(out_s[O_Y]),
      .Read(Read), .IncPC(IncPC), .Mdatain(Mdatain),
      .busMuxOut(busMuxOut), .encoderOut(encoderOut),
      .BusMuxInR0(tap_r[0]),   .BusMuxInR1(tap_r[1]),   .BusMuxInR2(tap_r[2]),   .BusMuxInR3(tap_r[3]),
      .BusMuxInR4(tap_r[4]),   .BusMuxInR5(tap_r[5]),   .BusMuxInR6(tap_r[6]),   .BusMuxInR7(tap_r[7]),
      .BusMuxInR8(tap_r[8]),   .BusMuxInR9(tap_r[9]),   .BusMuxInR10(tap_r[10]), .BusMuxInR11(tap_r[11]),
      .BusMuxInR12(tap_r[12]), .BusMuxInR13(tap_r[13]), .BusMuxInR14(tap_r[14]), .BusMuxInR15(tap_r[15]),
      .BusMuxInHI(tap_hi), .BusMuxInLO(tap_lo), .BusMuxInZhi(tap_zhi), .BusMuxInZlo(tap_zlo),
      .BusMuxInPC(tap_pc), .BusMuxInMDR(tap_mdr), .BusMuxInInport(tap_inp), .BusMuxInY(tap_y)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Lowest active source code owns the bus; Zout is an alias of ZLO, and no source means code 31.
   function automatic int model_code();
      int best = 31;
      for (int i = 0; i < 25; i++) begin
         if (out_s[i]) begin
            int c = (i == O_Z) ? 19 : i;
            if (c < best) best = c;
         end
      end
      return best;
   endfunction

   function automatic logic [31:0] model_bus();
      int c = model_code();
      if (c < 16) return mr[c];
      case (c)
         16: return mhi;
         17: return mlo;
         18: return mzhi;
         19: return mzlo;
         20: return mpc;
         21: return mmdr;
         22: return minp;
         24: return my;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mr[i] = 32'h0;
      {mhi, mlo, mzhi, mzlo, mpc, mmdr, minp, my, mmar, mir} = '0;
   endtask

   task automatic model_edge();
      logic [31:0] b, zl;
      if (Clear) begin
         model_reset();
         return;
      end
      b  = model_bus();
      zl = IncPC ? b + 32'd1 : (AND_s ? (my & b) : (my + b));
      for (int i = 0; i < 16; i++) if (in_s[i]) mr[i] = b;
      if (in_s[I_HI])  mhi  = b;
      if (in_s[I_LO])  mlo  = b;
      if (in_s[I_PC])  mpc  = b;
      if (in_s[I_MDR]) mmdr = Read ? Mdatain : b;
      if (in_s[I_INP]) minp = b;
      if (in_s[I_Y])   my   = b;
      if (in_s[I_MAR]) mmar = b;
      if (in_s[I_IR])  mir  = b;
      if (in_s[I_Z]) begin
         mzhi = 32'h0;
         mzlo = zl;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 16; i++) chk($sformatf("%s_r%0d", tag, i), tap_r[i], mr[i]);
      chk({tag, "_hi"},  tap_hi,  mhi);
      chk({tag, "_lo"},  tap_lo,  mlo);
      chk({tag, "_zhi"}, tap_zhi, mzhi);
      chk({tag, "_zlo"}, tap_zlo, mzlo);
      chk({tag, "_pc"},  tap_pc,  mpc);
      chk({tag, "_mdr"}, tap_mdr, mmdr);
      chk({tag, "_inp"}, tap_inp, minp);
      chk({tag, "_y"},   tap_y,   my);
      chk({tag, "_mar"}, dut.mar_val, mmar);
      chk({tag, "_ir"},  dut.ir_val,  mir);
   endtask

   task automatic idle();
      Clear = 1'b0; in_s = '0; out_s = '0; AND_s = 1'b0; Read = 1'b0; IncPC = 1'b0;
   endtask

   // Inputs are driven just after a falling edge; bus/encoder checked before the rising edge, taps after it.
   task automatic step(input string tag);
      #1;
      chk({tag, "_enc"}, {27'b0, encoderOut}, 32'(model_code()));
      chk({tag, "_bus"}, busMuxOut, model_bus());
      model_edge();
      @(posedge Clock);
      #1;
      check_all(tag);
      @(negedge Clock);
      idle();
   endtask

   task automatic mdr_load(input logic [31:0] v);
      Mdatain = v; Read = 1'b1; in_s[I_MDR] = 1'b1;
      step("mdr_ld");
   endtask

   initial begin
      idle();
      Mdatain = 32'h0;
      model_reset();
      @(negedge Clock);

      Clear = 1'b1;
      step("reset");
      step("idle");
      chk("idle_enc_none", {27'b0, encoderOut}, 32'd31);
      chk("idle_bus_zero", busMuxOut, 32'h0);

      mdr_load(32'hF0000012);
      out_s[O_MDR] = 1'b1; in_s[3] = 1'b1;
      #1 chk("mdr_enc21", {27'b0, encoderOut}, 32'd21);
      step("r3_ld");
      chk("r3_val", tap_r[3], 32'hF0000012);
      mdr_load(32'h00000004);
      out_s[O_MDR] = 1'b1; in_s[5] = 1'b1;
      step("r5_ld");
      mdr_load(32'h00000018);
      out_s[O_MDR] = 1'b1; in_s[1] = 1'b1;
      step("r1_ld");
      chk("r1_val", tap_r[1], 32'h00000018);

      out_s[O_PC] = 1'b1; in_s[I_MAR] = 1'b1; IncPC = 1'b1; in_s[I_Z] = 1'b1;
      step("fetch1");
      chk("fetch1_z", tap_zlo, 32'h1);
      chk("fetch1_mar", dut.mar_val, 32'h0);
      out_s[O_ZLO] = 1'b1; in_s[I_PC] = 1'b1; Read = 1'b1; in_s[I_MDR] = 1'b1; Mdatain = 32'h40918000;
      step("fetch2");
      chk("fetch2_pc", tap_pc, 32'h1);
      chk("fetch2_mdr", tap_mdr, 32'h40918000);
      out_s[O_MDR] = 1'b1; in_s[I_IR] = 1'b1;
      step("fetch3");
      chk("fetch3_ir", dut.ir_val, 32'h40918000);

      out_s[3] = 1'b1; in_s[I_Y] = 1'b1;
      step("and_y");
      chk("and_y_val", tap_y, 32'hF0000012);
      out_s[5] = 1'b1; AND_s = 1'b1; in_s[I_Z] = 1'b1;
      step("and_z");
      chk("and_zlo", tap_zlo, 32'h0);
      out_s[O_ZLO] = 1'b1; in_s[1] = 1'b1;
      step("and_r1");
      chk("and_r1_val", tap_r[1], 32'h0);
      mdr_load(32'hFFFF00FF);
      out_s[O_MDR] = 1'b1; in_s[I_Y] = 1'b1;
      step("and2_y");
      mdr_load(32'h0F0F0F0F);
      out_s[O_MDR] = 1'b1; AND_s = 1'b1; in_s[I_Z] = 1'b1;
      step("and2_z");
      chk("and2_zlo", tap_zlo, 32'h0F0F000F);

      mdr_load(32'hFFFFFFFF);
      out_s[O_MDR] = 1'b1; in_s[I_Y] = 1'b1;
      step("add_y");
      mdr_load(32'h00000001);
      out_s[O_MDR] = 1'b1; in_s[I_Z] = 1'b1;
      step("add_z");
      chk("add_wrap_zlo", tap_zlo, 32'h0);
      chk("add_zhi", tap_zhi, 32'h0);
      out_s[2] = 1'b1; out_s[7] = 1'b1;
      #1 chk("prio_enc2", {27'b0, encoderOut}, 32'd2);
      step("prio");

      out_s[O_MDR] = 1'b1; IncPC = 1'b1; in_s[I_Z] = 1'b1;
      step("pre_clr");
      out_s[O_ZLO] = 1'b1; in_s[I_PC] = 1'b1; in_s[I_Z] = 1'b1; IncPC = 1'b1; Clear = 1'b1;
      step("mid_clr");
      chk("mid_clr_pc", tap_pc, 32'h0);
      chk("mid_clr_zlo", tap_zlo, 32'h0);

      for (int n = 0; n < 400; n++) begin
         int k = $urandom_range(0, 3);
         for (int j = 0; j < k; j++) out_s[$urandom_range(0, 24)] = 1'b1;
         for (int j = 0; j < 25; j++) in_s[j] = ($urandom_range(0, 7) == 0);
         AND_s   = $urandom_range(0, 1) == 1;
         IncPC   = $urandom_range(0, 3) == 0;
         Read    = $urandom_range(0, 1) == 1;
         Mdatain = $urandom;
         Clear   = $urandom_range(0, 49) == 0;
         step("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
